// File: rtl/ro_sample_uart_rx_if.sv
// Receiver-side bundle for the ring-oscillator sensor UART link.
// The DUT takes the slave view; the capture logic (or bench) takes master.
interface ro_sample_uart_rx_if #(
    parameter int WORD_BYTES = 3
);
    logic                    rx;
    logic [7:0]              byte_data;
    logic                    byte_valid;
    logic [8*WORD_BYTES-1:0] word;
    logic                    word_valid;
    logic                    frame_err;
    logic                    timeout_err;
    logic                    busy;

    modport master (
        output rx,
        input  byte_data, byte_valid, word, word_valid,
        input  frame_err, timeout_err, busy
    );

    modport slave (
        input  rx,
        output byte_data, byte_valid, word, word_valid,
        output frame_err, timeout_err, busy
    );
endinterface

// File: rtl/ro_sample_uart_rx.sv
// 8N1 UART receiver for the ring-oscillator sensor link; bytes are
// reassembled LSB-first into WORD_BYTES-wide sample words.
module ro_sample_uart_rx #(
    parameter int CLK_FREQ     = 10000,
    parameter int BAUD         = 1000,
    parameter int WORD_BYTES   = 3,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic clk,
    input  logic rst,
    ro_sample_uart_rx_if.slave bus
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int WW   = 8 * WORD_BYTES;
    localparam int TO   = TIMEOUT_BITS * CPB;
    localparam int CW   = $clog2(CPB);
    localparam int TW   = $clog2(TO);
    localparam int IW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic [2:0]      nbit_q, nbit_d;
    logic [7:0]      shift_q, shift_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WW-1:0]   shadow_q, shadow_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [7:0]      byte_q, byte_d;
    logic [WW-1:0]   word_q, word_d;
    logic            bv_q, bv_d, wv_q, wv_d;
    logic            fe_q, fe_d, te_q, te_d;
    logic            busy_q;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        nbit_d   = nbit_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tcnt_d   = tcnt_q;
        byte_d   = byte_q;
        word_d   = word_q;
        bv_d     = 1'b0;
        wv_d     = 1'b0;
        fe_d     = 1'b0;
        te_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // a start edge wins over a timeout landing on the same cycle
                if (!rx_s) begin
                    state_d = START;
                    bcnt_d  = CW'(HALF - 1);
                    tcnt_d  = '0;
                end else if (idx_q != '0) begin
                    if (tcnt_q == TW'(TO - 1)) begin
                        te_d     = 1'b1;
                        idx_d    = '0;
                        shadow_d = '0;
                        tcnt_d   = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            START: begin
                if (bcnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bcnt_d  = CW'(CPB - 1);
                        nbit_d  = '0;
                    end
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            DATA: begin
                if (bcnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bcnt_d  = CW'(CPB - 1);
                    if (nbit_q == 3'd7) state_d = STOP;
                    else nbit_d = nbit_q + 1'b1;
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            STOP: begin
                if (bcnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        bv_d    = 1'b1;
                        byte_d  = shift_q;
                        tcnt_d  = '0;
                        for (int k = 0; k < WORD_BYTES; k++) begin
                            if (idx_q == IW'(k)) shadow_d[8*k +: 8] = shift_q;
                        end
                        if (idx_q == IW'(WORD_BYTES - 1)) begin
                            word_d = shadow_d;
                            wv_d   = 1'b1;
                            idx_d  = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = BRK;
                        fe_d    = 1'b1;
                        idx_d   = '0;
                    end
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            BRK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            bcnt_q   <= '0;
            nbit_q   <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            tcnt_q   <= '0;
            byte_q   <= '0;
            word_q   <= '0;
            bv_q     <= 1'b0;
            wv_q     <= 1'b0;
            fe_q     <= 1'b0;
            te_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], bus.rx};
            bcnt_q   <= bcnt_d;
            nbit_q   <= nbit_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tcnt_q   <= tcnt_d;
            byte_q   <= byte_d;
            word_q   <= word_d;
            bv_q     <= bv_d;
            wv_q     <= wv_d;
            fe_q     <= fe_d;
            te_q     <= te_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign bus.byte_data   = byte_q;
    assign bus.byte_valid  = bv_q;
    assign bus.word        = word_q;
    assign bus.word_valid  = wv_q;
    assign bus.frame_err   = fe_q;
    assign bus.timeout_err = te_q;
    assign bus.busy        = busy_q;
endmodule
